// File: rtl/instr_decode_stage.sv
// instr_decode_stage: MIPS-subset ID stage with regfile and load-use stall.
// Optional feature macro ID_WB_BYPASS_EN: write-through register reads.
module instr_decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int RA_W  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2*XLEN-1:0]           reg_if_id,
    input  logic                        if_valid,
    input  logic                        flush,
    input  logic                        wb_we,
    input  logic [RA_W-1:0]             wb_addr,
    input  logic [XLEN-1:0]             wb_data,
    output logic [4*XLEN+3*RA_W+9:0]    reg_id_ex,
    output logic                        id_valid,
    output logic                        stall_if
);

    localparam logic [9:0] C_RW   = 10'h200;
    localparam logic [9:0] C_MR   = 10'h100;
    localparam logic [9:0] C_MW   = 10'h080;
    localparam logic [9:0] C_M2R  = 10'h040;
    localparam logic [9:0] C_ASRC = 10'h020;
    localparam logic [9:0] C_BR   = 10'h010;
    localparam logic [9:0] C_J    = 10'h008;
    localparam logic [9:0] A_ADD  = 10'h000;
    localparam logic [9:0] A_SUB  = 10'h001;
    localparam logic [9:0] A_AND  = 10'h002;
    localparam logic [9:0] A_OR   = 10'h003;
    localparam logic [9:0] A_SLT  = 10'h004;

    logic [XLEN-1:0] rf [NREGS];

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [5:0]      op;
    logic [5:0]      funct;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic [RA_W-1:0] rd;

    assign pc    = reg_if_id[2*XLEN-1:XLEN];
    assign instr = reg_if_id[XLEN-1:0];
    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];

    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] dst;
    logic [9:0]      ctrl;
    logic            rs_used;
    logic            rt_used;

    // Register file read; r0 is hardwired to zero
    always_comb begin
        rs_val = (rs == '0) ? '0 : rf[rs];
        rt_val = (rt == '0) ? '0 : rf[rt];
`ifdef ID_WB_BYPASS_EN
        if (wb_we && wb_addr != '0 && wb_addr == rs)
            rs_val = wb_data;
        if (wb_we && wb_addr != '0 && wb_addr == rt)
            rt_val = wb_data;
`endif
    end

    // Opcode/funct decode into control word, destination and immediate
    always_comb begin
        ctrl    = '0;
        dst     = '0;
        imm     = {{16{instr[15]}}, instr[15:0]};
        rs_used = 1'b0;
        rt_used = 1'b0;
        unique case (op)
            6'h00: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
                unique case (funct)
                    6'h20: begin ctrl = C_RW | A_ADD; dst = rd; end
                    6'h22: begin ctrl = C_RW | A_SUB; dst = rd; end
                    6'h24: begin ctrl = C_RW | A_AND; dst = rd; end
                    6'h25: begin ctrl = C_RW | A_OR;  dst = rd; end
                    6'h2A: begin ctrl = C_RW | A_SLT; dst = rd; end
                    default: ;
                endcase
            end
            6'h23: begin
                ctrl    = C_RW | C_MR | C_M2R | C_ASRC | A_ADD;
                dst     = rt;
                rs_used = 1'b1;
            end
            6'h2B: begin
                ctrl    = C_MW | C_ASRC | A_ADD;
                rs_used = 1'b1;
                rt_used = 1'b1;
            end
            6'h04: begin
                ctrl    = C_BR | A_SUB;
                rs_used = 1'b1;
                rt_used = 1'b1;
            end
            6'h08: begin
                ctrl    = C_RW | C_ASRC | A_ADD;
                dst     = rt;
                rs_used = 1'b1;
            end
            6'h02: begin
                ctrl = C_J;
                imm  = {pc[31:28], instr[25:0], 2'b00};
            end
            default: ;
        endcase
    end

    logic [RA_W-1:0] ex_dst;
    logic            ex_mem_read;
    logic            load_use;

    assign ex_dst      = reg_id_ex[14:10];
    assign ex_mem_read = reg_id_ex[8];
    assign load_use    = id_valid && ex_mem_read && ex_dst != '0 &&
                         ((rs_used && ex_dst == rs) ||
                          (rt_used && ex_dst == rt));
    assign stall_if    = load_use && !flush && !rst;

    // Register file write port from WB; reset clears every entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else if (wb_we && wb_addr != '0) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // ID/EX register: flush and load-use both insert a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_id_ex <= '0;
            id_valid  <= 1'b0;
        end else if (flush || load_use) begin
            reg_id_ex <= '0;
            id_valid  <= 1'b0;
        end else begin
            reg_id_ex <= {pc, rs_val, rt_val, imm, rs, rt, dst,
                          ctrl & {10{if_valid}}};
            id_valid  <= if_valid;
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: random + directed bench for the ID stage.
// A spec-level decode/regfile model is compared every cycle.
module tb_instr_decode_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  reg_if_id;
    logic         if_valid;
    logic         flush;
    logic         wb_we;
    logic [4:0]   wb_addr;
    logic [31:0]  wb_data;
    logic [152:0] reg_id_ex;
    logic         id_valid;
    logic         stall_if;

    instr_decode_stage dut (
        .clk       (clk),
        .rst       (rst),
        .reg_if_id (reg_if_id),
        .if_valid  (if_valid),
        .flush     (flush),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .reg_id_ex (reg_id_ex),
        .id_valid  (id_valid),
        .stall_if  (stall_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0]  m_rf [32];
    logic [152:0] m_word;
    logic         m_valid;
    logic         m_full;
    logic         m_known = 1'b0;
    logic         m_held  = 1'b0;

    task automatic chk(input string nm, input logic [152:0] act,
                       input logic [152:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (wb_we && wb_addr == a) return wb_data;
`endif
        return m_rf[a];
    endfunction

    function automatic logic [152:0] m_decode(input logic [31:0] pc,
                                              input logic [31:0] ins,
                                              output logic urs,
                                              output logic urt);
        logic [9:0]  c  = 10'd0;
        logic [4:0]  d  = 5'd0;
        logic [31:0] im = {{16{ins[15]}}, ins[15:0]};
        urs = 1'b0;
        urt = 1'b0;
        case (ins[31:26])
            6'h00: begin
                urs = 1'b1; urt = 1'b1;
                d = ins[15:11];
                case (ins[5:0])
                    6'h20: c = 10'h200;
                    6'h22: c = 10'h201;
                    6'h24: c = 10'h202;
                    6'h25: c = 10'h203;
                    6'h2A: c = 10'h204;
                    default: d = 5'd0;
                endcase
            end
            6'h23: begin c = 10'h360; d = ins[20:16]; urs = 1'b1; end
            6'h2B: begin c = 10'h0A0; urs = 1'b1; urt = 1'b1; end
            6'h04: begin c = 10'h011; urs = 1'b1; urt = 1'b1; end
            6'h08: begin c = 10'h220; d = ins[20:16]; urs = 1'b1; end
            6'h02: begin
                c  = 10'h008;
                im = {pc[31:28], ins[25:0], 2'b00};
            end
            default: ;
        endcase
        return {pc, m_read(ins[25:21]), m_read(ins[20:16]), im,
                ins[25:21], ins[20:16], d, c};
    endfunction

    function automatic logic m_stall();
        logic urs, urt;
        logic [152:0] w;
        logic [4:0] ed;
        w  = m_decode(reg_if_id[63:32], reg_if_id[31:0], urs, urt);
        ed = m_word[14:10];
        return !rst && !flush && m_valid && m_word[8] && ed != 5'd0 &&
               ((urs && ed == reg_if_id[25:21]) ||
                (urt && ed == reg_if_id[20:16]));
    endfunction

    // Reference model advances on each rising edge
    always @(posedge clk) begin
        logic urs, urt, st;
        logic [152:0] nxt;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_word  = '0;
            m_valid = 1'b0;
            m_full  = 1'b1;
            m_held  = 1'b0;
            m_known = 1'b1;
        end else begin
            st  = m_stall();
            nxt = m_decode(reg_if_id[63:32], reg_if_id[31:0], urs, urt);
            if (flush || st) begin
                m_word  = '0;
                m_valid = 1'b0;
                m_full  = 1'b0;
            end else begin
                m_word  = nxt;
                m_valid = if_valid;
                m_full  = if_valid;
                if (!if_valid) m_word[9:0] = 10'd0;
            end
            if (wb_we && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
            m_held = st;
        end
    end

    // Compare process, away from the active edge
    always @(negedge clk) begin
        if (m_known) begin
            chk("stall_if", 153'(stall_if), 153'(m_stall()));
            chk("id_valid", 153'(id_valid), 153'(m_valid));
            if (m_full)
                chk("id_ex", reg_id_ex, m_word);
            else
                chk("bubble_ctrl", 153'(reg_id_ex[9:0]), 153'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [4:0]  a  = 5'($urandom_range(0, 7));
        logic [4:0]  b  = 5'($urandom_range(0, 7));
        logic [4:0]  c  = 5'($urandom_range(0, 7));
        logic [15:0] im = 16'($urandom);
        logic [5:0]  fn;
        case ($urandom_range(0, 4))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            default: fn = 6'h2A;
        endcase
        case ($urandom_range(0, 8))
            0, 1: return {6'h00, a, b, c, 5'd0, fn};
            2, 3: return {6'h23, a, b, im};
            4: return {6'h2B, a, b, im};
            5: return {6'h04, a, b, im};
            6: return {6'h08, a, b, im};
            7: return {6'h02, 26'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        if_valid  = 1'b0;
        flush     = 1'b0;
        wb_we     = 1'b0;
        wb_addr   = 5'd0;
        wb_data   = 32'd0;
        reg_if_id = 64'd0;
        cyc();
        cyc();
        chk("rst_word", reg_id_ex, 153'd0);
        chk("rst_valid", 153'(id_valid), 153'd0);
        chk("rst_stall", 153'(stall_if), 153'd0);
        rst = 1'b0;

        reg_if_id = {32'h0, 32'h03FF1820};
        if_valid  = 1'b1;
        cyc();
        chk("r31_zero", 153'(reg_id_ex[120:89]), 153'd0);

        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hAA;
        if_valid = 1'b0;
        cyc();
        wb_we = 1'b0;
        reg_if_id = {32'h4, 32'h00A51820};
        if_valid  = 1'b1;
        cyc();
        chk("add_rs", 153'(reg_id_ex[120:89]), 153'hAA);
        chk("add_rt", 153'(reg_id_ex[88:57]), 153'hAA);
        chk("add_dst", 153'(reg_id_ex[14:10]), 153'd3);
        chk("add_ctrl", 153'(reg_id_ex[9:0]), 153'h200);
        chk("add_pc", 153'(reg_id_ex[152:121]), 153'h4);
        chk("add_valid", 153'(id_valid), 153'd1);

        reg_if_id = {32'h8, 32'h8C220004};
        cyc();
        chk("lw_ctrl", 153'(reg_id_ex[9:0]), 153'h360);
        reg_if_id = {32'hC, 32'h00422020};
        #1;
        chk("lu_stall", 153'(stall_if), 153'd1);
        cyc();
        chk("lu_bub_v", 153'(id_valid), 153'd0);
        chk("lu_bub_c", 153'(reg_id_ex[9:0]), 153'd0);
        chk("lu_unstall", 153'(stall_if), 153'd0);
        cyc();
        chk("lu_issue_v", 153'(id_valid), 153'd1);
        chk("lu_issue_d", 153'(reg_id_ex[14:10]), 153'd4);

        reg_if_id = {32'h10, 32'h8C220004};
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("fl_valid", 153'(id_valid), 153'd0);
        chk("fl_ctrl", 153'(reg_id_ex[9:0]), 153'd0);
        chk("fl_stall", 153'(stall_if), 153'd0);

        reg_if_id = {32'h14, 32'h8C220004};
        cyc();
        reg_if_id = {32'h18, 32'h00422020};
        flush = 1'b1;
        #1;
        chk("fl_mask_st", 153'(stall_if), 153'd0);
        cyc();
        flush = 1'b0;
        chk("fl_mask_v", 153'(id_valid), 153'd0);

        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
        reg_if_id = {32'h1C, 32'h20E80001};
        cyc();
        wb_we = 1'b0;
`ifdef ID_WB_BYPASS_EN
        chk("byp_rs", 153'(reg_id_ex[120:89]), 153'h1234);
`else
        chk("byp_rs", 153'(reg_id_ex[120:89]), 153'h0);
`endif
        chk("addi_ctrl", 153'(reg_id_ex[9:0]), 153'h220);

        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        if_valid = 1'b0;
        cyc();
        wb_we = 1'b0;
        reg_if_id = {32'h20, 32'h00000820};
        if_valid  = 1'b1;
        cyc();
        chk("r0_rs", 153'(reg_id_ex[120:89]), 153'd0);
        chk("r0_rt", 153'(reg_id_ex[88:57]), 153'd0);

        reg_if_id = {32'h24, 32'hFC221234};
        cyc();
        chk("bad_ctrl", 153'(reg_id_ex[9:0]), 153'd0);
        chk("bad_dst", 153'(reg_id_ex[14:10]), 153'd0);
        chk("bad_valid", 153'(id_valid), 153'd1);

        reg_if_id = {32'hA0000000, 32'h08000010};
        cyc();
        chk("j_imm", 153'(reg_id_ex[56:25]), 153'hA0000040);
        chk("j_ctrl", 153'(reg_id_ex[9:0]), 153'h008);

        reg_if_id = {32'h28, 32'h1000FFFF};
        cyc();
        chk("beq_imm", 153'(reg_id_ex[56:25]), 153'hFFFFFFFF);
        chk("beq_ctrl", 153'(reg_id_ex[9:0]), 153'h011);

        reg_if_id = {32'h2C, 32'hAC220008};
        cyc();
        chk("sw_ctrl", 153'(reg_id_ex[9:0]), 153'h0A0);
        chk("sw_dst", 153'(reg_id_ex[14:10]), 153'd0);

        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 199) == 0);
            flush   = ($urandom_range(0, 15) == 0);
            wb_we   = 1'($urandom_range(0, 1));
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            if (!m_held) begin
                if_valid  = ($urandom_range(0, 7) != 0);
                reg_if_id = {$urandom, gen_instr()};
            end
            cyc();
        end
        rst = 1'b0;
        flush = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
